// File: rtl/ahb_interconnect.sv
// AHB-Lite read-path interconnect: address decode to NUM_SLAVES slaves,
// data-phase response mux, and a built-in default slave that answers
// unmapped NONSEQ/SEQ transfers with a two-cycle ERROR response.
module ahb_interconnect #(
  parameter int NUM_SLAVES  = 4,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 4
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  input  logic                         ERR_CLR,
  output logic                         ERR_FLAG,
  output logic [7:0]                   ERR_COUNT
);

  // Slave index width covers the largest legal slave count (8).
  localparam int IDX_W = 3;

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_SLAVE = 2'd1;
  localparam logic [1:0] SEL_DEF   = 2'd2;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [31:0]      region_p0;
  logic             slave_hit_p0;
  logic             err_qual_p0;
  logic [1:0]       dsel_kind_p1;
  logic [IDX_W-1:0] dsel_idx_p1;
  logic [1:0]       ds_state;
  logic [1:0]       ds_next;
  logic             err_entry;
  logic             unused_ok;

  // ---- address phase (p0): region decode ----
  assign region_p0    = 32'(HADDR[31 -: REGION_BITS]);
  assign slave_hit_p0 = region_p0 < 32'(NUM_SLAVES);
  // An unmapped transfer only starts an error when it is a real transfer
  // (NONSEQ/SEQ) accepted by the bus.
  assign err_qual_p0  = HREADY && !slave_hit_p0 && HTRANS[1];
  assign unused_ok    = ^{HADDR[31-REGION_BITS:0], HTRANS[0]};

  // One-hot slave select, purely combinational and independent of HTRANS.
  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (region_p0 == 32'(i)) HSEL_S[i] = 1'b1;
  end

  // ---- data phase (p1): select register advances only when the bus is ready ----
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_kind_p1 <= SEL_NONE;
      dsel_idx_p1  <= '0;
    end else if (HREADY) begin
      if (slave_hit_p0) begin
        dsel_kind_p1 <= SEL_SLAVE;
        dsel_idx_p1  <= region_p0[IDX_W-1:0];
      end else begin
        dsel_kind_p1 <= SEL_DEF;
        dsel_idx_p1  <= '0;
      end
    end
  end

  // Default-slave next state: ERR1 is the wait cycle, ERR2 the final cycle.
  always_comb begin
    ds_next = DS_IDLE;
    case (ds_state)
      DS_IDLE: ds_next = err_qual_p0 ? DS_ERR1 : DS_IDLE;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = err_qual_p0 ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  assign err_entry = (ds_next == DS_ERR1);

  // Default-slave state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) ds_state <= DS_IDLE;
    else        ds_state <= ds_next;
  end

  // Saturating decode-error counter; ERR_CLR deliberately has no effect here.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                              ERR_COUNT <= 8'd0;
    else if (err_entry && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)         ERR_FLAG <= 1'b0;
    else if (err_entry) ERR_FLAG <= 1'b1;
    else if (ERR_CLR)   ERR_FLAG <= 1'b0;
  end

  // Response mux: selected slave passes through with no added latency;
  // NONE and an idle default slave answer ready/OKAY with zero data.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (dsel_kind_p1)
      SEL_SLAVE: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (dsel_idx_p1 == IDX_W'(i)) begin
            HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[i];
          end
        end
      end
      SEL_DEF: begin
        if (ds_state == DS_ERR1) begin
          HREADY = 1'b0;
          HRESP  = 1'b1;
        end else if (ds_state == DS_ERR2) begin
          HREADY = 1'b1;
          HRESP  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed bench for ahb_interconnect: a 4x32 instance carries the main
// sequence; 2x64 and 8x64 instances share the master signals for the
// parameter-variant reads and decode errors.
module tb_ahb_interconnect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        err_clr = 1'b0;

  logic [3:0]   hsel4, hreadyout_s4, hresp_s4;
  logic [127:0] hrdata_s4;
  logic [31:0]  hrdata4;
  logic         hready4, hresp4, err_flag4;
  logic [7:0]   err_count4;

  logic [1:0]   hsel2, hreadyout_s2, hresp_s2;
  logic [127:0] hrdata_s2;
  logic [63:0]  hrdata2;
  logic         hready2, hresp2, err_flag2;
  logic [7:0]   err_count2;

  logic [7:0]   hsel8, hreadyout_s8, hresp_s8;
  logic [511:0] hrdata_s8;
  logic [63:0]  hrdata8;
  logic         hready8, hresp8, err_flag8;
  logic [7:0]   err_count8;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] S0_D = 32'h1111_0000;
  localparam logic [31:0] S1_D = 32'h2222_1111;
  localparam logic [31:0] S2_D = 32'hCAFE_F00D;
  localparam logic [31:0] S3_D = 32'h4444_3333;

  always #5 clk = ~clk;

  ahb_interconnect #(.NUM_SLAVES(4), .DATA_W(32), .REGION_BITS(4)) dut4 (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HTRANS(htrans),
    .HSEL_S(hsel4), .HRDATA_S(hrdata_s4), .HREADYOUT_S(hreadyout_s4),
    .HRESP_S(hresp_s4), .HRDATA(hrdata4), .HREADY(hready4), .HRESP(hresp4),
    .ERR_CLR(err_clr), .ERR_FLAG(err_flag4), .ERR_COUNT(err_count4));

  ahb_interconnect #(.NUM_SLAVES(2), .DATA_W(64), .REGION_BITS(4)) dut2 (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HTRANS(htrans),
    .HSEL_S(hsel2), .HRDATA_S(hrdata_s2), .HREADYOUT_S(hreadyout_s2),
    .HRESP_S(hresp_s2), .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2),
    .ERR_CLR(err_clr), .ERR_FLAG(err_flag2), .ERR_COUNT(err_count2));

  ahb_interconnect #(.NUM_SLAVES(8), .DATA_W(64), .REGION_BITS(4)) dut8 (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HTRANS(htrans),
    .HSEL_S(hsel8), .HRDATA_S(hrdata_s8), .HREADYOUT_S(hreadyout_s8),
    .HRESP_S(hresp_s8), .HRDATA(hrdata8), .HREADY(hready8), .HRESP(hresp8),
    .ERR_CLR(err_clr), .ERR_FLAG(err_flag8), .ERR_COUNT(err_count8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    hrdata_s4    = {S3_D, S2_D, S1_D, S0_D};
    hreadyout_s4 = 4'hF;
    hresp_s4     = 4'h0;
    hrdata_s2    = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    hreadyout_s2 = 2'b11;
    hresp_s2     = 2'b00;
    for (int i = 0; i < 8; i++)
      hrdata_s8[i*64 +: 64] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    hrdata_s8[2*64 +: 64] = 64'hCAFE_F00D_1234_5678;
    hreadyout_s8 = 8'hFF;
    hresp_s8     = 8'h00;

    // reset state
    #2 rst = 1'b1;
    #6;
    chk("rst_hready", 64'(hready4), 64'h1);
    chk("rst_hresp", 64'(hresp4), 64'h0);
    chk("rst_hrdata", 64'(hrdata4), 64'h0);
    chk("rst_flag", 64'(err_flag4), 64'h0);
    chk("rst_count", 64'(err_count4), 64'h0);
    chk("rst_hsel", 64'(hsel4), 64'h1);
    tick(); rst = 1'b0;

    // read slave 2 with one wait state
    haddr = 32'h2000_0010; htrans = 2'b10; settle();
    chk("rd2_hsel", 64'(hsel4), 64'h4);
    chk("rd2_addr_hready", 64'(hready4), 64'h1);
    tick(); haddr = 32'h0; htrans = 2'b00; hreadyout_s4[2] = 1'b0; settle();
    chk("rd2_wait_hready", 64'(hready4), 64'h0);
    tick(); hreadyout_s4[2] = 1'b1; settle();
    chk("rd2_hready", 64'(hready4), 64'h1);
    chk("rd2_hrdata", 64'(hrdata4), 64'(S2_D));
    chk("rd2_hresp", 64'(hresp4), 64'h0);

    // back-to-back slave 0 (stalled 3 cycles) then slave 1
    tick(); haddr = 32'h0000_0000; htrans = 2'b10; settle();
    chk("b2b_hsel0", 64'(hsel4), 64'h1);
    tick(); haddr = 32'h1000_0000; htrans = 2'b10; hreadyout_s4[0] = 1'b0; settle();
    chk("b2b_hsel1", 64'(hsel4), 64'h2);
    chk("b2b_stall1", 64'(hready4), 64'h0);
    tick(); settle();
    chk("b2b_stall2", 64'(hready4), 64'h0);
    chk("b2b_stall2_data", 64'(hrdata4), 64'(S0_D));
    tick(); settle();
    chk("b2b_stall3", 64'(hready4), 64'h0);
    tick(); hreadyout_s4[0] = 1'b1; settle();
    chk("b2b_s0_done", 64'(hready4), 64'h1);
    chk("b2b_s0_data", 64'(hrdata4), 64'(S0_D));
    tick(); haddr = 32'h3000_0000; htrans = 2'b00; hresp_s4[1] = 1'b1; settle();
    chk("b2b_s1_data", 64'(hrdata4), 64'(S1_D));
    chk("b2b_s1_resp", 64'(hresp4), 64'h1);
    chk("b2b_s1_hready", 64'(hready4), 64'h1);

    // NONSEQ decode error
    tick(); hresp_s4[1] = 1'b0; haddr = 32'hF000_0000; htrans = 2'b10; settle();
    chk("err_hsel", 64'(hsel4), 64'h0);
    chk("err_addr_hready", 64'(hready4), 64'h1);
    chk("err_addr_hresp", 64'(hresp4), 64'h0);
    tick(); haddr = 32'h0; htrans = 2'b00; settle();
    chk("err1_hready", 64'(hready4), 64'h0);
    chk("err1_hresp", 64'(hresp4), 64'h1);
    chk("err1_hrdata", 64'(hrdata4), 64'h0);
    chk("err1_flag", 64'(err_flag4), 64'h1);
    chk("err1_count", 64'(err_count4), 64'h1);
    tick(); settle();
    chk("err2_hready", 64'(hready4), 64'h1);
    chk("err2_hresp", 64'(hresp4), 64'h1);
    tick(); settle();
    chk("err_done_hready", 64'(hready4), 64'h1);
    chk("err_done_hresp", 64'(hresp4), 64'h0);

    // IDLE and BUSY to the default slave: no wait, OKAY, no count
    tick(); haddr = 32'hF000_0000; htrans = 2'b00; settle();
    tick(); htrans = 2'b01; settle();
    chk("idle_def_hready", 64'(hready4), 64'h1);
    chk("idle_def_hresp", 64'(hresp4), 64'h0);
    chk("idle_def_count", 64'(err_count4), 64'h1);
    tick(); htrans = 2'b10; settle();
    chk("busy_def_hready", 64'(hready4), 64'h1);
    chk("busy_def_hresp", 64'(hresp4), 64'h0);
    chk("busy_def_count", 64'(err_count4), 64'h1);

    // 300 consecutive NONSEQ errors: one entry every odd edge
    tick(); settle();
    chk("run_first_count", 64'(err_count4), 64'h2);
    chk("run_first_hready", 64'(hready4), 64'h0);
    for (int k = 2; k <= 600; k++) begin
      tick();
      if (k == 505) begin
        settle();
        chk("run_count_254", 64'(err_count4), 64'd254);
      end
    end
    haddr = 32'h0; htrans = 2'b00; settle();
    chk("sat_count", 64'(err_count4), 64'd255);
    chk("sat_flag", 64'(err_flag4), 64'h1);
    chk("sat_err2_hresp", 64'(hresp4), 64'h1);
    tick(); err_clr = 1'b1; settle();
    chk("clr_pre_flag", 64'(err_flag4), 64'h1);
    tick(); err_clr = 1'b0; settle();
    chk("clr_flag", 64'(err_flag4), 64'h0);
    chk("clr_count", 64'(err_count4), 64'd255);

    // error entry and clear on the same edge: flag stays set
    haddr = 32'hF000_0000; htrans = 2'b10; err_clr = 1'b1;
    tick(); err_clr = 1'b0; haddr = 32'h0; htrans = 2'b00; settle();
    chk("setclr_flag", 64'(err_flag4), 64'h1);
    chk("setclr_count", 64'(err_count4), 64'd255);
    chk("setclr_err1", 64'(hready4), 64'h0);

    // reset while in ERR1, then a normal read of slave 1
    rst = 1'b1; settle();
    chk("rst_err_hready", 64'(hready4), 64'h1);
    chk("rst_err_hresp", 64'(hresp4), 64'h0);
    chk("rst_err_count", 64'(err_count4), 64'h0);
    chk("rst_err_flag", 64'(err_flag4), 64'h0);
    tick(); rst = 1'b0; haddr = 32'h1000_0004; htrans = 2'b10; settle();
    chk("post_rst_hready", 64'(hready4), 64'h1);
    chk("post_rst_hrdata", 64'(hrdata4), 64'h0);
    tick(); haddr = 32'h0; htrans = 2'b00; settle();
    chk("post_rst_rd1", 64'(hrdata4), 64'(S1_D));
    chk("post_rst_rd1_hresp", 64'(hresp4), 64'h0);
    chk("post_rst_rd1_count", 64'(err_count4), 64'h0);

    // parameter variants: 2 slaves and 8 slaves, 64-bit data
    rst = 1'b1;
    tick(); rst = 1'b0; haddr = 32'h2000_0010; htrans = 2'b10; settle();
    chk("v8_hsel", 64'(hsel8), 64'h04);
    chk("v2_hsel", 64'(hsel2), 64'h0);
    chk("v2_addr_hready", 64'(hready2), 64'h1);
    tick(); haddr = 32'h0; htrans = 2'b00; hreadyout_s8[2] = 1'b0; settle();
    chk("v8_wait", 64'(hready8), 64'h0);
    chk("v2_err1_hready", 64'(hready2), 64'h0);
    chk("v2_err1_hresp", 64'(hresp2), 64'h1);
    chk("v2_err1_count", 64'(err_count2), 64'h1);
    tick(); hreadyout_s8[2] = 1'b1; settle();
    chk("v8_rd_hready", 64'(hready8), 64'h1);
    chk("v8_rd_data", hrdata8, 64'hCAFE_F00D_1234_5678);
    chk("v8_rd_hresp", 64'(hresp8), 64'h0);
    chk("v2_err2_hready", 64'(hready2), 64'h1);
    chk("v2_err2_hresp", 64'(hresp2), 64'h1);
    tick(); haddr = 32'hF000_0000; htrans = 2'b10; settle();
    chk("v8_err_hsel", 64'(hsel8), 64'h0);
    chk("v2_err_hsel", 64'(hsel2), 64'h0);
    chk("v8_s0_data", hrdata8, 64'h0101_0101_0101_0101);
    tick(); haddr = 32'h0; htrans = 2'b00; settle();
    chk("v8_err1_hready", 64'(hready8), 64'h0);
    chk("v8_err1_hresp", 64'(hresp8), 64'h1);
    chk("v8_err1_count", 64'(err_count8), 64'h1);
    chk("v8_err1_flag", 64'(err_flag8), 64'h1);
    chk("v2_err1b_count", 64'(err_count2), 64'h2);
    chk("v2_err1b_hready", 64'(hready2), 64'h0);
    tick(); settle();
    chk("v8_err2_hready", 64'(hready8), 64'h1);
    chk("v8_err2_hresp", 64'(hresp8), 64'h1);
    chk("v2_err2b_hresp", 64'(hresp2), 64'h1);
    tick(); haddr = 32'h1000_0000; htrans = 2'b10; settle();
    chk("v8_done_hresp", 64'(hresp8), 64'h0);
    chk("v8_done_hready", 64'(hready8), 64'h1);
    chk("v2_s0_data", hrdata2, 64'h0123_4567_89AB_CDEF);
    tick(); haddr = 32'h0; htrans = 2'b00; settle();
    chk("v2_s1_data", hrdata2, 64'hFEDC_BA98_7654_3210);
    chk("v8_s1_data", hrdata8, 64'h0202_0202_0202_0202);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
